// File: rtl/seq_multiplier.sv
// Signed WIDTH x WIDTH multiplier: magnitude shift-add over WIDTH cycles,
// sign fix-up in a final cycle, CPSR-style flags matching the divider.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             busy,
    output logic             done,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT1   = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_PW = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mag_x_q, mag_x_d;
    logic [WIDTH-1:0] mag_y_q, mag_y_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;

    logic [PW-1:0]    prod_q, prod_d;
    logic             done_q, done_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    result;

    // Upper half plus multiplicand keeps its carry so the shift never loses it.
    always_comb begin
        addend = mag_y_q[0] ? {1'b0, mag_x_q} : '0;
        sum    = {1'b0, acc_q[PW-1:WIDTH]} + addend;
        result = neg_q ? (~acc_q + ONE_PW) : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        mag_x_d    = mag_x_q;
        mag_y_d    = mag_y_q;
        neg_d      = neg_q;
        acc_d      = acc_q;
        count_d    = count_q;
        prod_d     = prod_q;
        negative_d = negative_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // 100..0 negates to itself, read here as unsigned 2^(WIDTH-1).
                    mag_x_d = x[WIDTH-1] ? (~x + ONE_W) : x;
                    mag_y_d = y[WIDTH-1] ? (~y + ONE_W) : y;
                    neg_d   = x[WIDTH-1] ^ y[WIDTH-1];
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                mag_y_d = mag_y_q >> 1;
                count_d = count_q + CNT1;
                if (count_q == LAST) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                prod_d     = result;
                negative_d = result[PW-1];
                zero_d     = (result == '0);
                overflow_d = (result[PW-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_x_q    <= '0;
            mag_y_q    <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            count_q    <= '0;
            prod_q     <= '0;
            done_q     <= 1'b0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_x_q    <= mag_x_d;
            mag_y_q    <= mag_y_d;
            neg_q      <= neg_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            prod_q     <= prod_d;
            done_q     <= done_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign prod_lo  = prod_q[WIDTH-1:0];
    assign prod_hi  = prod_q[PW-1:WIDTH];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign negative = negative_q;
    assign zero     = zero_q;
    assign cout     = 1'b0;
    assign overflow = overflow_q;

endmodule
